// File: rtl/std_lane_strm_buf.sv
// Stack-bus downstream lane buffer: NUM_STRMS elastic FIFOs with per-stream
// cntl framing checkers and an optional lockstep release of all streams.
module std_lane_strm_buf #(
  parameter int unsigned NUM_STRMS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_poweron,
  input  logic                                   cfg_lockstep,
  input  logic                                   err_clr,
  input  logic [NUM_STRMS-1:0]                   std__buf__strm_valid,
  input  logic [2*NUM_STRMS-1:0]                 std__buf__strm_cntl,
  input  logic [DATA_W*NUM_STRMS-1:0]            std__buf__strm_data,
  input  logic [DATA_W*NUM_STRMS-1:0]            std__buf__strm_data_mask,
  output logic [NUM_STRMS-1:0]                   buf__std__strm_ready,
  output logic [NUM_STRMS-1:0]                   buf__stOp__strm_valid,
  output logic [2*NUM_STRMS-1:0]                 buf__stOp__strm_cntl,
  output logic [DATA_W*NUM_STRMS-1:0]            buf__stOp__strm_data,
  output logic [DATA_W*NUM_STRMS-1:0]            buf__stOp__strm_data_mask,
  input  logic [NUM_STRMS-1:0]                   stOp__buf__strm_ready,
  output logic [NUM_STRMS-1:0]                   buf__sys__framing_err,
  output logic [NUM_STRMS*($clog2(DEPTH)+1)-1:0] buf__sys__occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } frm_state_e;

  logic [NUM_STRMS-1:0] full;
  logic [NUM_STRMS-1:0] nonempty;
  logic [NUM_STRMS-1:0] push;
  logic [NUM_STRMS-1:0] pop;
  logic                 joint_valid;
  logic                 joint_pop;

  // Lockstep selection is purely combinational on registered counts, so a
  // mode change applies on the following edge without dropping a beat.
  assign joint_valid = &nonempty;
  assign joint_pop   = joint_valid & (&stOp__buf__strm_ready);

  always_comb begin
    buf__stOp__strm_valid = '0;
    pop                   = '0;
    if (cfg_lockstep) begin
      buf__stOp__strm_valid = {NUM_STRMS{joint_valid}};
      pop                   = {NUM_STRMS{joint_pop}};
    end else begin
      buf__stOp__strm_valid = nonempty;
      pop                   = nonempty & stOp__buf__strm_ready;
    end
  end

  for (genvar s = 0; s < NUM_STRMS; s++) begin : g_strm
    logic [1:0]        cntl_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] mask_mem_q [DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    frm_state_e        st_q;
    frm_state_e        st_d;
    logic              err_q;
    logic              err_d;
    logic              frm_bad;
    logic [1:0]        cntl_in;

    assign cntl_in     = std__buf__strm_cntl[2*s +: 2];
    assign full[s]     = (cnt_q == CW'(DEPTH));
    assign nonempty[s] = (cnt_q != '0);
    assign push[s]     = std__buf__strm_valid[s] & ~full[s];

    always_comb begin
      cnt_d = cnt_q;
      case ({push[s], pop[s]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          cntl_mem_q[i] <= '0;
          data_mem_q[i] <= '0;
          mask_mem_q[i] <= '0;
        end
      end else begin
        cnt_q <= cnt_d;
        if (push[s]) begin
          cntl_mem_q[wptr_q] <= cntl_in;
          data_mem_q[wptr_q] <= std__buf__strm_data[DATA_W*s +: DATA_W];
          mask_mem_q[wptr_q] <= std__buf__strm_data_mask[DATA_W*s +: DATA_W];
          wptr_q             <= wptr_q + PW'(1);
        end
        if (pop[s]) begin
          rptr_q <= rptr_q + PW'(1);
        end
      end
    end

    always_comb begin
      st_d    = st_q;
      frm_bad = 1'b0;
      if (push[s]) begin
        case (st_q)
          ST_IDLE: begin
            case (cntl_in)
              CNTL_SOM:     st_d = ST_IN_PKT;
              CNTL_SOM_EOM: st_d = ST_IDLE;
              default:      frm_bad = 1'b1;
            endcase
          end
          ST_IN_PKT: begin
            case (cntl_in)
              CNTL_MOM: st_d = ST_IN_PKT;
              CNTL_EOM: st_d = ST_IDLE;
              CNTL_SOM: frm_bad = 1'b1;
              default: begin
                frm_bad = 1'b1;
                st_d    = ST_IDLE;
              end
            endcase
          end
          default: st_d = ST_IDLE;
        endcase
      end
      // A new error outranks a coincident clear.
      err_d = err_clr ? 1'b0 : err_q;
      if (frm_bad) begin
        err_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
        st_q  <= ST_IDLE;
        err_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        err_q <= err_d;
      end
    end

    assign buf__std__strm_ready[s]                       = ~full[s];
    assign buf__stOp__strm_cntl[2*s +: 2]                = cntl_mem_q[rptr_q];
    assign buf__stOp__strm_data[DATA_W*s +: DATA_W]      = data_mem_q[rptr_q];
    assign buf__stOp__strm_data_mask[DATA_W*s +: DATA_W] = mask_mem_q[rptr_q];
    assign buf__sys__framing_err[s]                      = err_q;
    assign buf__sys__occupancy[CW*s +: CW]               = cnt_q;
  end

endmodule
